// File: rtl/dmem_arbiter_if.sv
// Requester-side bus of the data-RAM arbiter: request fields in, grant and registered response out.
// master = core or loader, slave = arbiter.
interface dmem_arbiter_if #(
    parameter int XLEN      = 32,
    parameter int ADDRWIDTH = 10
);
    logic                 req;
    logic                 we;
    logic [ADDRWIDTH-1:0] addr;
    logic [XLEN-1:0]      wdata;
    logic [1:0]           size;
    logic                 uns;
    logic                 gnt;
    logic                 rvalid;
    logic [XLEN-1:0]      rdata;
    logic                 err;

    modport master (
        output req, we, addr, wdata, size, uns,
        input  gnt, rvalid, rdata, err
    );

    modport slave (
        input  req, we, addr, wdata, size, uns,
        output gnt, rvalid, rdata, err
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Round-robin two-port sequencer for the byte-addressed data RAM, one access in flight.
// Grant in IDLE, RAM access in ACCESS, registered response one cycle later.
module dmem_arbiter #(
    parameter int XLEN      = 32,
    parameter int ADDRWIDTH = 10
) (
    input  logic                 clk,
    input  logic                 rst_n,
    dmem_arbiter_if.slave        a_port,
    dmem_arbiter_if.slave        b_port,
    output logic [ADDRWIDTH-1:0] o_ram_addr,
    output logic [XLEN-1:0]      o_ram_wrData,
    output logic                 o_ram_wrEn,
    output logic                 o_ram_byteEn,
    output logic                 o_ram_halfEn,
    output logic                 o_ram_wordEn,
    output logic                 o_ram_unsignedEn,
    input  logic [XLEN-1:0]      i_ram_dataOut
);

    // state    | meaning
    // S_IDLE   | sample requests, grant winner, capture its fields
    // S_ACCESS | drive RAM from captured fields, register response
    typedef enum logic {S_IDLE, S_ACCESS} state_t;

    state_t               r_state;
    state_t               w_next;

    logic                 r_last_gnt;   // 1 = B won last
    logic                 r_we;
    logic [ADDRWIDTH-1:0] r_addr;
    logic [XLEN-1:0]      r_wdata;
    logic [1:0]           r_size;
    logic                 r_uns;
    logic                 r_port;
    logic                 r_err;

    logic                 r_a_rvalid, r_b_rvalid;
    logic [XLEN-1:0]      r_a_rdata, r_b_rdata;
    logic                 r_a_err, r_b_err;

    logic                 w_pick_b;
    logic                 w_start;
    logic                 w_a_gnt, w_b_gnt;
    logic                 w_cap_we;
    logic [ADDRWIDTH-1:0] w_cap_addr;
    logic [XLEN-1:0]      w_cap_wdata;
    logic [1:0]           w_cap_size;
    logic                 w_cap_uns;
    logic                 w_cap_err;
    logic [XLEN-1:0]      w_resp_data;

    // With both requesting, the port that did not win last time goes next.
    assign w_pick_b    = b_port.req & (~a_port.req | ~r_last_gnt);
    assign w_start     = (r_state == S_IDLE) & (a_port.req | b_port.req);

    assign w_cap_we    = w_pick_b ? b_port.we    : a_port.we;
    assign w_cap_addr  = w_pick_b ? b_port.addr  : a_port.addr;
    assign w_cap_wdata = w_pick_b ? b_port.wdata : a_port.wdata;
    assign w_cap_size  = w_pick_b ? b_port.size  : a_port.size;
    assign w_cap_uns   = w_pick_b ? b_port.uns   : a_port.uns;
    assign w_cap_err   = (w_cap_size == 2'b11) |
                         ((w_cap_size == 2'b01) & w_cap_addr[0]) |
                         ((w_cap_size == 2'b10) & (w_cap_addr[1:0] != 2'b00));

    assign w_resp_data = (!r_we && !r_err) ? i_ram_dataOut : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (w_start) w_next = S_ACCESS;
            S_ACCESS: w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_a_gnt          = 1'b0;
        w_b_gnt          = 1'b0;
        o_ram_addr       = '0;
        o_ram_wrData     = '0;
        o_ram_wrEn       = 1'b0;
        o_ram_byteEn     = 1'b0;
        o_ram_halfEn     = 1'b0;
        o_ram_wordEn     = 1'b0;
        o_ram_unsignedEn = 1'b0;
        if (rst_n && w_start) begin
            w_a_gnt = ~w_pick_b;
            w_b_gnt = w_pick_b;
        end
        // A flagged access never touches the RAM.
        if (r_state == S_ACCESS && !r_err) begin
            o_ram_addr       = r_addr;
            o_ram_wrData     = r_wdata;
            o_ram_wrEn       = r_we;
            o_ram_byteEn     = (r_size == 2'b00);
            o_ram_halfEn     = (r_size == 2'b01);
            o_ram_wordEn     = (r_size == 2'b10);
            o_ram_unsignedEn = r_uns;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last_gnt <= 1'b1;
            r_we       <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_size     <= 2'b00;
            r_uns      <= 1'b0;
            r_port     <= 1'b0;
            r_err      <= 1'b0;
            r_a_rvalid <= 1'b0;
            r_b_rvalid <= 1'b0;
            r_a_rdata  <= '0;
            r_b_rdata  <= '0;
            r_a_err    <= 1'b0;
            r_b_err    <= 1'b0;
        end else begin
            r_a_rvalid <= 1'b0;
            r_b_rvalid <= 1'b0;
            if (w_start) begin
                r_last_gnt <= w_pick_b;
                r_port     <= w_pick_b;
                r_we       <= w_cap_we;
                r_addr     <= w_cap_addr;
                r_wdata    <= w_cap_wdata;
                r_size     <= w_cap_size;
                r_uns      <= w_cap_uns;
                r_err      <= w_cap_err;
            end
            if (r_state == S_ACCESS) begin
                if (r_port) begin
                    r_b_rvalid <= 1'b1;
                    r_b_rdata  <= w_resp_data;
                    r_b_err    <= r_err;
                end else begin
                    r_a_rvalid <= 1'b1;
                    r_a_rdata  <= w_resp_data;
                    r_a_err    <= r_err;
                end
            end
        end
    end

    assign a_port.gnt    = w_a_gnt;
    assign b_port.gnt    = w_b_gnt;
    assign a_port.rvalid = r_a_rvalid;
    assign b_port.rvalid = r_b_rvalid;
    assign a_port.rdata  = r_a_rdata;
    assign b_port.rdata  = r_b_rdata;
    assign a_port.err    = r_a_err;
    assign b_port.err    = r_b_err;

endmodule
